// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared sizes, FU ids, CDB/request types and the wrap-aware ROB age compare
package cdb_arbiter_pkg;
   localparam int NUM_FU     = 4;
   localparam int DATA_WIDTH = 32;
   localparam int PHY_WIDTH  = 6;
   localparam int ROB_WIDTH  = 5;
   localparam int TAG_WIDTH  = ROB_WIDTH + 1;
   localparam int PTR_WIDTH  = $clog2(NUM_FU);
   localparam int FU_ALU     = 0;
   localparam int FU_BRU     = 1;
   localparam int FU_LSU     = 2;
   localparam int FU_MUL     = 3;

   typedef logic [TAG_WIDTH-1:0] rob_tag_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [PHY_WIDTH-1:0]  phy_rd;
      rob_tag_t              rob_idx;
   } fu_req_t;

   typedef struct packed {
      logic                  valid;
      logic [DATA_WIDTH-1:0] data;
      logic [PHY_WIDTH-1:0]  phy_rd;
      rob_tag_t              rob_idx;
   } cdb_packet_t;

   // a is younger than b when its distance from the ROB head is larger (modulo the wrap bit)
   function automatic logic rob_younger(rob_tag_t a, rob_tag_t b, rob_tag_t head);
      rob_tag_t age_a;
      rob_tag_t age_b;
      age_a = a - head;
      age_b = b - head;
      return age_a > age_b;
   endfunction
endpackage

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: functional-unit request bus, flush/age inputs and CDB broadcast
interface cdb_arbiter_if;
   import cdb_arbiter_pkg::*;
   logic [NUM_FU-1:0]            fu_valid;
   logic [NUM_FU*DATA_WIDTH-1:0] fu_data;
   logic [NUM_FU*PHY_WIDTH-1:0]  fu_phy_rd;
   logic [NUM_FU*TAG_WIDTH-1:0]  fu_rob_idx;
   logic [NUM_FU-1:0]            fu_ready;
   rob_tag_t                     rob_head;
   logic                         flush;
   rob_tag_t                     flush_rob_idx;
   logic                         cdb_valid;
   logic [DATA_WIDTH-1:0]        cdb_data;
   logic [PHY_WIDTH-1:0]         cdb_phy_rd;
   rob_tag_t                     cdb_rob_idx;

   modport master (
      output fu_valid, fu_data, fu_phy_rd, fu_rob_idx, rob_head, flush, flush_rob_idx,
      input  fu_ready, cdb_valid, cdb_data, cdb_phy_rd, cdb_rob_idx
   );

   modport slave (
      input  fu_valid, fu_data, fu_phy_rd, fu_rob_idx, rob_head, flush, flush_rob_idx,
      output fu_ready, cdb_valid, cdb_data, cdb_phy_rd, cdb_rob_idx
   );
endinterface

// File: rtl/cdb_arbiter_rr.sv
// cdb_arbiter_rr: combinational round-robin picker; one-hot grant and next pointer from requests and pointer
module cdb_arbiter_rr #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req_i,
   input  logic [$clog2(N)-1:0] ptr_i,
   output logic [N-1:0]         gnt_o,
   output logic [$clog2(N)-1:0] ptr_o
);
   localparam int PW = $clog2(N);

   int   idx;
   logic found;

   // Scan from the pointer upward with wrap; first request wins, pointer moves past it
   always_comb begin
      gnt_o = '0;
      ptr_o = ptr_i;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr_i) + k) % N;
         if (!found && req_i[idx[PW-1:0]]) begin
            gnt_o[idx[PW-1:0]] = 1'b1;
            ptr_o              = PW'((idx + 1) % N);
            found              = 1'b1;
         end
      end
   end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: one-result-per-cycle CDB writeback scheduler with flush kill; CDB_AGE_PRIORITY_EN selects oldest-first with starve counters
import cdb_arbiter_pkg::*;

module cdb_arbiter (
   input logic          clk,
   input logic          rst,
   cdb_arbiter_if.slave bus
);
   fu_req_t                req [NUM_FU];
   logic [NUM_FU-1:0]      killed;
   logic [NUM_FU-1:0]      cand;
   logic [NUM_FU-1:0]      gnt;
   logic [PTR_WIDTH-1:0]   rr_ptr_q;
   logic [PTR_WIDTH-1:0]   rr_ptr_d;
   fu_req_t                sel;
   cdb_packet_t            cdb_q;
   cdb_packet_t            cdb_d;

   // Unpack the flat unit buses and drop requests younger than a flushing branch
   always_comb begin
      for (int i = 0; i < NUM_FU; i++) begin
         req[i].data    = bus.fu_data[i*DATA_WIDTH +: DATA_WIDTH];
         req[i].phy_rd  = bus.fu_phy_rd[i*PHY_WIDTH +: PHY_WIDTH];
         req[i].rob_idx = bus.fu_rob_idx[i*TAG_WIDTH +: TAG_WIDTH];
         killed[i]      = bus.flush && rob_younger(req[i].rob_idx, bus.flush_rob_idx, bus.rob_head);
      end
      cand = bus.fu_valid & ~killed;
   end

`ifdef CDB_AGE_PRIORITY_EN
   logic [NUM_FU-1:0][3:0] starve_q;
   logic [NUM_FU-1:0][3:0] starve_d;
   logic                   sat_hit;
   logic                   have;
   rob_tag_t               best_tag;

   assign rr_ptr_d = '0;

   // Saturated starvers win (lowest index first), otherwise the oldest live request
   always_comb begin
      gnt      = '0;
      sat_hit  = 1'b0;
      have     = 1'b0;
      best_tag = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         if (!sat_hit && cand[i] && starve_q[i] == 4'hF) begin
            sat_hit = 1'b1;
            gnt[i]  = 1'b1;
         end
      end
      for (int i = 0; i < NUM_FU; i++) begin
         if (!sat_hit && cand[i] && (!have || rob_younger(best_tag, req[i].rob_idx, bus.rob_head))) begin
            have     = 1'b1;
            best_tag = req[i].rob_idx;
            gnt      = '0;
            gnt[i]   = 1'b1;
         end
      end
   end

   // Each live request that loses counts up to 15; a grant clears it
   always_comb begin
      for (int i = 0; i < NUM_FU; i++)
         starve_d[i] = gnt[i] ? 4'd0 : (cand[i] && starve_q[i] != 4'hF) ? starve_q[i] + 4'd1 : starve_q[i];
   end

   // Starve counter state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) starve_q <= '0;
      else     starve_q <= starve_d;
   end
`else
   cdb_arbiter_rr #(.N(NUM_FU)) u_rr (
      .req_i (cand),
      .ptr_i (rr_ptr_q),
      .gnt_o (gnt),
      .ptr_o (rr_ptr_d)
   );
`endif

   // Route the granted payload into the next CDB entry; payload holds when idle
   always_comb begin
      sel = '0;
      for (int i = 0; i < NUM_FU; i++)
         if (gnt[i]) sel = req[i];
      cdb_d.valid   = |gnt && !(bus.flush && rob_younger(sel.rob_idx, bus.flush_rob_idx, bus.rob_head));
      cdb_d.data    = |gnt ? sel.data    : cdb_q.data;
      cdb_d.phy_rd  = |gnt ? sel.phy_rd  : cdb_q.phy_rd;
      cdb_d.rob_idx = |gnt ? sel.rob_idx : cdb_q.rob_idx;
   end

   // CDB register and round-robin pointer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cdb_q    <= '0;
         rr_ptr_q <= '0;
      end else begin
         cdb_q    <= cdb_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign bus.fu_ready    = rst ? '0 : gnt;
   assign bus.cdb_valid   = cdb_q.valid;
   assign bus.cdb_data    = cdb_q.data;
   assign bus.cdb_phy_rd  = cdb_q.phy_rd;
   assign bus.cdb_rob_idx = cdb_q.rob_idx;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: table vectors, directed corner sequences and random traffic against a reference model
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   typedef struct {
      logic [3:0] v;
      logic [5:0] t0, t1, t2, t3, hd;
      logic       f;
      logic [5:0] fi;
      logic [3:0] rdy;
      logic       cv;
      logic [5:0] ct;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;

   logic        u_v [NUM_FU];
   logic [31:0] u_d [NUM_FU];
   logic [5:0]  u_p [NUM_FU];
   logic [5:0]  u_t [NUM_FU];
   logic [5:0]  head, fl_idx;
   logic        fl;

   int          m_ptr;
   int          m_cnt [NUM_FU];
   logic        m_v;
   logic [31:0] m_d;
   logic [5:0]  m_p, m_t;

   vec_t tbl [12];

   cdb_arbiter_if bus();
   cdb_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic apply();
      for (int i = 0; i < NUM_FU; i++) begin
         bus.fu_valid[i]                            = u_v[i];
         bus.fu_data[i*DATA_WIDTH +: DATA_WIDTH]    = u_d[i];
         bus.fu_phy_rd[i*PHY_WIDTH +: PHY_WIDTH]    = u_p[i];
         bus.fu_rob_idx[i*TAG_WIDTH +: TAG_WIDTH]   = u_t[i];
      end
      bus.rob_head      = head;
      bus.flush         = fl;
      bus.flush_rob_idx = fl_idx;
   endtask

   task automatic set_unit(int i, logic v, logic [5:0] t);
      u_v[i] = v;
      u_t[i] = t;
      u_d[i] = 32'hC0DE_0000 | {26'd0, t};
      u_p[i] = t ^ 6'h15;
   endtask

   function automatic int age(logic [5:0] t);
      return (int'(t) - int'(head)) & 63;
   endfunction

   function automatic bit live(int i);
      return u_v[i] && !(fl && age(u_t[i]) > age(fl_idx));
   endfunction

   function automatic int pick();
      int g = -1;
`ifdef CDB_AGE_PRIORITY_EN
      for (int i = 0; i < NUM_FU; i++)
         if (live(i) && m_cnt[i] == 15) return i;
      for (int i = 0; i < NUM_FU; i++)
         if (live(i) && (g < 0 || age(u_t[i]) < age(u_t[g]))) g = i;
`else
      for (int k = 0; k < NUM_FU; k++)
         if (live((m_ptr + k) % NUM_FU)) return (m_ptr + k) % NUM_FU;
`endif
      return g;
   endfunction

   task automatic m_reset();
      m_ptr = 0;
      m_v = 1'b0;
      m_d = '0;
      m_p = '0;
      m_t = '0;
      for (int i = 0; i < NUM_FU; i++) m_cnt[i] = 0;
   endtask

   task automatic m_update(int g);
      for (int i = 0; i < NUM_FU; i++)
         if (i == g) m_cnt[i] = 0;
         else if (live(i) && m_cnt[i] < 15) m_cnt[i]++;
      m_v = (g >= 0);
      if (g >= 0) begin
         m_d   = u_d[g];
         m_p   = u_p[g];
         m_t   = u_t[g];
         m_ptr = (g + 1) % NUM_FU;
      end
   endtask

   task automatic cycle(output int g);
      apply();
      g = pick();
      #1;
      chk("fu_ready", {28'd0, bus.fu_ready}, g < 0 ? 32'd0 : 32'd1 << g);
      @(posedge clk);
      m_update(g);
      #1;
      chk("cdb_valid", {31'd0, bus.cdb_valid}, {31'd0, m_v});
      chk("cdb_data", bus.cdb_data, m_d);
      chk("cdb_phy_rd", {26'd0, bus.cdb_phy_rd}, {26'd0, m_p});
      chk("cdb_rob_idx", {26'd0, bus.cdb_rob_idx}, {26'd0, m_t});
   endtask

   initial begin
      int g;
      int lost;
      bit got;
      tbl[0]  = '{4'b1111, 6'd1,  6'd2,  6'd3, 6'd4, 6'd0,  1'b0, 6'd0,  4'b0001, 1'b1, 6'd1};
      tbl[1]  = '{4'b1111, 6'd1,  6'd2,  6'd3, 6'd4, 6'd0,  1'b0, 6'd0,  4'b0010, 1'b1, 6'd2};
      tbl[2]  = '{4'b1111, 6'd1,  6'd2,  6'd3, 6'd4, 6'd0,  1'b0, 6'd0,  4'b0100, 1'b1, 6'd3};
      tbl[3]  = '{4'b1111, 6'd1,  6'd2,  6'd3, 6'd4, 6'd0,  1'b0, 6'd0,  4'b1000, 1'b1, 6'd4};
      tbl[4]  = '{4'b0000, 6'd1,  6'd2,  6'd3, 6'd4, 6'd0,  1'b0, 6'd0,  4'b0000, 1'b0, 6'd4};
      tbl[5]  = '{4'b0011, 6'd3,  6'd7,  6'd0, 6'd0, 6'd0,  1'b1, 6'd5,  4'b0001, 1'b1, 6'd3};
      tbl[6]  = '{4'b0000, 6'd3,  6'd7,  6'd0, 6'd0, 6'd0,  1'b0, 6'd0,  4'b0000, 1'b0, 6'd3};
      tbl[7]  = '{4'b0011, 6'd31, 6'd33, 6'd0, 6'd0, 6'd30, 1'b1, 6'd32, 4'b0001, 1'b1, 6'd31};
      tbl[8]  = '{4'b0010, 6'd31, 6'd33, 6'd0, 6'd0, 6'd30, 1'b1, 6'd32, 4'b0000, 1'b0, 6'd31};
      tbl[9]  = '{4'b0010, 6'd31, 6'd33, 6'd0, 6'd0, 6'd30, 1'b0, 6'd0,  4'b0010, 1'b1, 6'd33};
      tbl[10] = '{4'b0101, 6'd5,  6'd0,  6'd6, 6'd0, 6'd0,  1'b0, 6'd0,  4'b0100, 1'b1, 6'd6};
      tbl[11] = '{4'b0101, 6'd5,  6'd0,  6'd6, 6'd0, 6'd0,  1'b0, 6'd0,  4'b0001, 1'b1, 6'd5};

      head = '0; fl = 1'b0; fl_idx = '0;
      for (int i = 0; i < NUM_FU; i++) set_unit(i, 1'b1, 6'(i + 1));
      m_reset();
      apply();
      #3;
      chk("rst_ready", {28'd0, bus.fu_ready}, 32'd0);
      chk("rst_cdb_valid", {31'd0, bus.cdb_valid}, 32'd0);
      @(posedge clk);
      #1;
      chk("rst_hold_ready", {28'd0, bus.fu_ready}, 32'd0);
      chk("rst_cdb_data", bus.cdb_data, 32'd0);
      chk("rst_cdb_tag", {26'd0, bus.cdb_rob_idx}, 32'd0);
      #2;
      rst = 1'b0;

`ifndef CDB_AGE_PRIORITY_EN
      for (int r = 0; r < 12; r++) begin
         set_unit(0, tbl[r].v[0], tbl[r].t0);
         set_unit(1, tbl[r].v[1], tbl[r].t1);
         set_unit(2, tbl[r].v[2], tbl[r].t2);
         set_unit(3, tbl[r].v[3], tbl[r].t3);
         head = tbl[r].hd; fl = tbl[r].f; fl_idx = tbl[r].fi;
         apply();
         #1;
         chk($sformatf("tbl%0d_ready", r), {28'd0, bus.fu_ready}, {28'd0, tbl[r].rdy});
         cycle(g);
         chk($sformatf("tbl%0d_cv", r), {31'd0, bus.cdb_valid}, {31'd0, tbl[r].cv});
         chk($sformatf("tbl%0d_tag", r), {26'd0, bus.cdb_rob_idx}, {26'd0, tbl[r].ct});
      end
`else
      head = '0; fl = 1'b0;
      for (int i = 0; i < NUM_FU; i++) set_unit(i, 1'b0, 6'd0);
      set_unit(3, 1'b1, 6'd1);
      set_unit(0, 1'b1, 6'd9);
      apply();
      #1;
      chk("age_oldest_ready", {28'd0, bus.fu_ready}, 32'd8);
      cycle(g);
      chk("age_oldest_tag", {26'd0, bus.cdb_rob_idx}, 32'd1);
      set_unit(3, 1'b0, 6'd0);
      set_unit(0, 1'b1, 6'd40);
      lost = 0;
      got = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
         set_unit(1, 1'b1, 6'(1 + n % 8));
         apply();
         #1;
         if (bus.fu_ready[0]) got = 1'b1;
         else lost++;
         cycle(g);
      end
      chk("starve_granted", {31'd0, got}, 32'd1);
      chk("starve_bound", {31'd0, lost <= 15}, 32'd1);
      set_unit(1, 1'b0, 6'd0);
`endif

      fl = 1'b0; head = 6'd12;
      for (int i = 0; i < NUM_FU; i++) set_unit(i, 1'b0, 6'd0);
      for (int n = 0; n < 3; n++) begin
         set_unit(2, 1'b1, 6'(20 + n));
         u_d[2] = 32'hA + n;
         cycle(g);
         chk($sformatf("single_data%0d", n), bus.cdb_data, 32'hA + n);
         chk($sformatf("single_valid%0d", n), {31'd0, bus.cdb_valid}, 32'd1);
      end

      for (int i = 0; i < NUM_FU; i++) set_unit(i, 1'b1, 6'(12 + i * 16));
      apply();
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_ready", {28'd0, bus.fu_ready}, 32'd0);
      chk("midrst_valid", {31'd0, bus.cdb_valid}, 32'd0);
      chk("midrst_data", bus.cdb_data, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_reset();

      head = 6'($urandom_range(63));
      for (int n = 0; n < 300; n++) begin
         cycle(g);
         for (int i = 0; i < NUM_FU; i++) begin
            if (!(live(i) && i != g)) begin
               set_unit(i, $urandom_range(2) != 0, head + 6'(i * 16) + 6'($urandom_range(15)));
               u_d[i] = $urandom;
               u_p[i] = 6'($urandom_range(63));
            end
         end
         fl = ($urandom_range(7) == 0);
         fl_idx = head + 6'($urandom_range(63));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
